light_show_sequencer: RTL and testbench

- Schedules the light-show routines (boot walk, shuttle, variant shuttle, snake A, snake B, text scroller) in a fixed cyclic order.
- Replaces hard-coded stopwatch start-time comparisons with a per-routine duration table, a per-routine step counter and start/done handshakes.
- Sits between the 10 Hz pulse generator and the routine datapaths; the output mux selects the routine indicated by RoutineSel.

---
 rtl/light_show_sequencer_if.sv | 31 +++
 rtl/light_show_sequencer.sv | 155 +++++++++++++++
 tb/tb_light_show_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/light_show_sequencer_if.sv
// Control and status bundle between the show sequencer and its surroundings.
// Latency: none, this is wiring only.
// Backpressure: none; the master side drives pulses and levels, the slave reports status.
interface light_show_sequencer_if #(
    parameter int STEP_W = 16
);
    logic              Tick;
    logic              Enable;
    logic              Pause;
    logic              Skip;
    logic              RoutineDone;
    logic [2:0]        RoutineSel;
    logic              StartPulse;
    logic [STEP_W-1:0] Step;
    logic              Active;
    logic              LastStep;
    logic [7:0]        CycleCount;
    logic              Wrapped;

    // Stimulus side: the pulse generator, control logic and routines.
    modport master (
        output Tick, Enable, Pause, Skip, RoutineDone,
        input  RoutineSel, StartPulse, Step, Active, LastStep, CycleCount, Wrapped
    );

    // Sequencer side.
    modport slave (
        input  Tick, Enable, Pause, Skip, RoutineDone,
        output RoutineSel, StartPulse, Step, Active, LastStep, CycleCount, Wrapped
    );
endinterface

// File: rtl/light_show_sequencer.sv
// Schedules the light-show routines cyclically, timing each one by a per-routine Tick budget.
// Latency: outputs registered; a finishing Tick gives ADVANCE next cycle and StartPulse the cycle after.
// Backpressure: none; Pause freezes the running routine, Skip/RoutineDone end it early.
module light_show_sequencer #(
    parameter int NUM_RTN = 6,
    parameter int STEP_W  = 16,
    parameter logic [NUM_RTN*STEP_W-1:0] DUR_TABLE =
        {16'd242, 16'd58, 16'd64, 16'd43, 16'd48, 16'd28}
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    light_show_sequencer_if.slave sif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSED  = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        cc_q, cc_d;
    logic              start_q, start_d;
    logic              active_q, active_d;
    logic              last_q, last_d;
    logic              wrap_q, wrap_d;
    logic [STEP_W-1:0] dur_cur;
    logic [STEP_W-1:0] dur_nxt;
    logic              step_at_end;
    logic              is_last_rtn;

    // Duration lookup; indices past the table read as zero (skipped).
    function automatic logic [STEP_W-1:0] dur_of(input logic [2:0] idx);
        logic [STEP_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_RTN; i++) begin
            if (idx == 3'(i)) begin
                d = DUR_TABLE[i*STEP_W +: STEP_W];
            end
        end
        return d;
    endfunction

    assign dur_cur     = dur_of(sel_q);
    // Only meaningful in RUN, where the duration is known to be nonzero.
    assign step_at_end = (step_q == dur_cur - STEP_W'(1));
    assign is_last_rtn = (sel_q == 3'(NUM_RTN - 1));

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        step_d   = step_q;
        cc_d     = cc_q;
        wrap_d   = 1'b0;
        dur_nxt  = '0;
        start_d  = 1'b0;
        active_d = 1'b0;
        last_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sif.Enable) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // A Tick seen here belongs to nobody and is dropped.
                state_d = (dur_cur == '0) ? S_ADVANCE : S_RUN;
            end
            S_RUN: begin
                if (sif.Skip || sif.RoutineDone) begin
                    state_d = S_ADVANCE;
                end else if (sif.Pause) begin
                    state_d = S_PAUSED;
                end else if (sif.Tick) begin
                    if (step_at_end) begin
                        state_d = S_ADVANCE;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            S_PAUSED: begin
                // Everything but Pause is ignored, including a Tick in the release cycle.
                if (!sif.Pause) begin
                    state_d = S_RUN;
                end
            end
            S_ADVANCE: begin
                state_d = sif.Enable ? S_LAUNCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Routine index moves on entry to ADVANCE so it is already valid there.
        if (state_d == S_ADVANCE && state_q != S_ADVANCE) begin
            if (is_last_rtn) begin
                sel_d  = 3'd0;
                cc_d   = cc_q + 8'd1;
                wrap_d = 1'b1;
            end else begin
                sel_d = sel_q + 3'd1;
            end
        end

        if (state_d == S_LAUNCH) begin
            step_d = '0;
        end

        dur_nxt  = dur_of(sel_d);
        start_d  = (state_d == S_LAUNCH) && (dur_nxt != '0);
        active_d = start_d || (state_d == S_RUN) || (state_d == S_PAUSED);
        last_d   = ((state_d == S_RUN) || (state_d == S_PAUSED)) &&
                   (step_d == dur_nxt - STEP_W'(1));
    end

    // State and output registers; reset drops straight to IDLE with all outputs low.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= S_IDLE;
            sel_q    <= 3'd0;
            step_q   <= '0;
            cc_q     <= 8'd0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            last_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            step_q   <= step_d;
            cc_q     <= cc_d;
            start_q  <= start_d;
            active_q <= active_d;
            last_q   <= last_d;
            wrap_q   <= wrap_d;
        end
    end

    assign sif.RoutineSel = sel_q;
    assign sif.StartPulse = start_q;
    assign sif.Step       = step_q;
    assign sif.Active     = active_q;
    assign sif.LastStep   = last_q;
    assign sif.CycleCount = cc_q;
    assign sif.Wrapped    = wrap_q;

endmodule

// File: tb/tb_light_show_sequencer.sv
// Bench for light_show_sequencer: a 3-routine instance {2,0,3} and a default 6-routine instance.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none; inputs driven away from the clock edge.
module tb_light_show_sequencer;

    localparam int SW = 16;
    localparam int L  = 800;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;
    always #5 Clock = ~Clock;

    light_show_sequencer_if #(.STEP_W(SW)) sa ();
    light_show_sequencer_if #(.STEP_W(SW)) sb ();

    light_show_sequencer #(
        .NUM_RTN  (3),
        .STEP_W   (SW),
        .DUR_TABLE({16'd3, 16'd0, 16'd2})
    ) u_small (
        .Clock (Clock),
        .ResetN(ResetN),
        .sif   (sa.slave)
    );

    light_show_sequencer u_big (
        .Clock (Clock),
        .ResetN(ResetN),
        .sif   (sb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int dur_s[3] = '{2, 0, 3};

    bit tk[L];
    bit sk[L];
    bit dn[L];
    bit pz[L];
    logic [30:0] ex[L];

    function automatic logic [30:0] pk_a();
        return {sa.RoutineSel, sa.Step, sa.StartPulse, sa.Active, sa.LastStep, sa.CycleCount, sa.Wrapped};
    endfunction

    function automatic logic [30:0] pk_b();
        return {sb.RoutineSel, sb.Step, sb.StartPulse, sb.Active, sb.LastStep, sb.CycleCount, sb.Wrapped};
    endfunction

    function automatic logic [30:0] pack(int sel, int step, bit st, bit act, bit last, int cc, bit wr);
        return {3'(sel), 16'(step), st, act, last, 8'(cc), wr};
    endfunction

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic zero_inputs();
        sa.Tick = 0; sa.Enable = 0; sa.Pause = 0; sa.Skip = 0; sa.RoutineDone = 0;
        sb.Tick = 0; sb.Enable = 0; sb.Pause = 0; sb.Skip = 0; sb.RoutineDone = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        ResetN = 0;
        cyc();
        cyc();
        ResetN = 1;
        cyc();
    endtask

    task automatic test_reset();
        zero_inputs();
        ResetN = 0;
        cyc();
        cyc();
        n_tests++;
        if (pk_a() !== 31'd0) begin n_fail++; $display("FAIL reset_small: got %h expected 0", pk_a()); end
        n_tests++;
        if (pk_b() !== 31'd0) begin n_fail++; $display("FAIL reset_big: got %h expected 0", pk_b()); end
        ResetN = 1;
        cyc();
        cyc();
        n_tests++;
        if (pk_a() !== 31'd0) begin n_fail++; $display("FAIL idle_no_enable: got %h expected 0", pk_a()); end
    endtask

    // Spec schedule {2,0,3} with a Tick every 4 cycles, up to the first wrap.
    task automatic test_schedule();
        int start_mask = 0;
        int steps_mask[8];
        bit wrapped_seen = 0;
        logic [7:0] cc_w = 0;
        logic [2:0] sel_w = 0;
        foreach (steps_mask[i]) steps_mask[i] = 0;
        do_reset();
        sa.Enable = 1;
        for (int k = 0; k < 120 && !wrapped_seen; k++) begin
            sa.Tick = (k % 4 == 3);
            cyc();
            sa.Tick = 0;
            if (sa.StartPulse === 1'b1) begin
                start_mask |= (1 << sa.RoutineSel);
                n_tests++;
                if (sa.Step !== 16'd0 || sa.Active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_state: step=%0d active=%0d expected step=0 active=1", sa.Step, sa.Active);
                end
            end
            if (sa.Active === 1'b1) steps_mask[sa.RoutineSel] |= (1 << sa.Step);
            if (sa.Wrapped === 1'b1) begin
                wrapped_seen = 1;
                cc_w = sa.CycleCount;
                sel_w = sa.RoutineSel;
            end
        end
        n_tests++;
        if (wrapped_seen !== 1'b1) begin n_fail++; $display("FAIL sched_wrap_timeout: got %0d expected 1", wrapped_seen); end
        n_tests++;
        if (start_mask !== 5) begin n_fail++; $display("FAIL sched_start_mask: got %b expected 101", start_mask); end
        n_tests++;
        if (steps_mask[0] !== 3) begin n_fail++; $display("FAIL sched_steps_r0: got %b expected 11", steps_mask[0]); end
        n_tests++;
        if (steps_mask[1] !== 0) begin n_fail++; $display("FAIL sched_steps_r1: got %b expected 0", steps_mask[1]); end
        n_tests++;
        if (steps_mask[2] !== 7) begin n_fail++; $display("FAIL sched_steps_r2: got %b expected 111", steps_mask[2]); end
        n_tests++;
        if (cc_w !== 8'd1 || sel_w !== 3'd0) begin
            n_fail++;
            $display("FAIL sched_wrap_vals: cc=%0d sel=%0d expected cc=1 sel=0", cc_w, sel_w);
        end
    endtask

    // Last-step Tick in N -> ADVANCE in N+1 -> StartPulse in N+2.
    task automatic test_latency();
        bit found = 0;
        do_reset();
        sa.Enable = 1;
        for (int k = 0; k < 100 && !found; k++) begin
            if (sa.RoutineSel === 3'd2 && sa.LastStep === 1'b1) found = 1;
            else begin
                sa.Tick = 1;
                cyc();
                sa.Tick = 0;
            end
        end
        n_tests++;
        if (found !== 1'b1 || sa.Step !== 16'd2) begin
            n_fail++;
            $display("FAIL lat_laststep: found=%0d step=%0d expected found=1 step=2", found, sa.Step);
        end
        sa.Tick = 1;
        cyc();
        sa.Tick = 0;
        n_tests++;
        if (pk_a() !== pack(0, 2, 0, 0, 0, 1, 1)) begin
            n_fail++;
            $display("FAIL lat_advance: got %h expected %h", pk_a(), pack(0, 2, 0, 0, 0, 1, 1));
        end
        cyc();
        n_tests++;
        if (pk_a() !== pack(0, 0, 1, 1, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL lat_launch: got %h expected %h", pk_a(), pack(0, 0, 1, 1, 0, 1, 0));
        end
    endtask

    // RoutineDone and Tick together at Step 5: Step holds, routine advances.
    task automatic test_done_tick();
        bit found = 0;
        do_reset();
        sb.Enable = 1;
        for (int k = 0; k < 50 && !found; k++) begin
            if (sb.Step === 16'd5 && sb.Active === 1'b1) found = 1;
            else begin
                sb.Tick = 1;
                cyc();
                sb.Tick = 0;
            end
        end
        n_tests++;
        if (found !== 1'b1 || sb.RoutineSel !== 3'd0) begin
            n_fail++;
            $display("FAIL done_reach5: found=%0d sel=%0d expected found=1 sel=0", found, sb.RoutineSel);
        end
        sb.Tick = 1;
        sb.RoutineDone = 1;
        cyc();
        sb.Tick = 0;
        sb.RoutineDone = 0;
        n_tests++;
        if (sb.Step !== 16'd5 || sb.RoutineSel !== 3'd1 || sb.Active !== 1'b0 || sb.StartPulse !== 1'b0) begin
            n_fail++;
            $display("FAIL done_advance: step=%0d sel=%0d act=%0d start=%0d expected 5 1 0 0",
                     sb.Step, sb.RoutineSel, sb.Active, sb.StartPulse);
        end
        cyc();
        n_tests++;
        if (sb.StartPulse !== 1'b1 || sb.Step !== 16'd0 || sb.RoutineSel !== 3'd1) begin
            n_fail++;
            $display("FAIL done_launch: start=%0d step=%0d sel=%0d expected 1 0 1", sb.StartPulse, sb.Step, sb.RoutineSel);
        end
    endtask

    // Pause at Step 3 across 10 Ticks and a Skip; release-cycle Tick is dropped.
    task automatic test_pause();
        bit found = 0;
        do_reset();
        sb.Enable = 1;
        for (int k = 0; k < 50 && !found; k++) begin
            if (sb.Step === 16'd3 && sb.Active === 1'b1) found = 1;
            else begin
                sb.Tick = 1;
                cyc();
                sb.Tick = 0;
            end
        end
        n_tests++;
        if (found !== 1'b1) begin n_fail++; $display("FAIL pause_reach3: got %0d expected 1", found); end
        sb.Pause = 1;
        sb.Tick = 1;
        cyc();
        sb.Tick = 0;
        n_tests++;
        if (sb.Step !== 16'd3 || sb.Active !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_entry: step=%0d act=%0d expected 3 1", sb.Step, sb.Active);
        end
        for (int k = 0; k < 30; k++) begin
            sb.Tick = (k % 3 == 0);
            sb.Skip = (k == 14);
            cyc();
            sb.Tick = 0;
            sb.Skip = 0;
            n_tests++;
            if (sb.Step !== 16'd3 || sb.RoutineSel !== 3'd0 || sb.Active !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_hold k=%0d: step=%0d sel=%0d act=%0d expected 3 0 1",
                         k, sb.Step, sb.RoutineSel, sb.Active);
            end
        end
        sb.Pause = 0;
        sb.Tick = 1;
        cyc();
        sb.Tick = 0;
        n_tests++;
        if (sb.Step !== 16'd3) begin n_fail++; $display("FAIL pause_release_tick: got %0d expected 3", sb.Step); end
        sb.Tick = 1;
        cyc();
        sb.Tick = 0;
        n_tests++;
        if (sb.Step !== 16'd4) begin n_fail++; $display("FAIL pause_resume_step: got %0d expected 4", sb.Step); end
    endtask

    // Enable dropped during routine 2: it completes, wraps, then the sequencer idles.
    task automatic test_enable_drop();
        bit found = 0;
        bit wr = 0;
        int max_step = 1;
        do_reset();
        sa.Enable = 1;
        for (int k = 0; k < 60 && !found; k++) begin
            if (sa.RoutineSel === 3'd2 && sa.Active === 1'b1 && sa.Step === 16'd1) found = 1;
            else begin
                sa.Tick = 1;
                cyc();
                sa.Tick = 0;
            end
        end
        n_tests++;
        if (found !== 1'b1) begin n_fail++; $display("FAIL drop_reach: got %0d expected 1", found); end
        sa.Enable = 0;
        for (int k = 0; k < 20 && !wr; k++) begin
            sa.Tick = 1;
            cyc();
            if (sa.Active === 1'b1 && sa.RoutineSel === 3'd2 && int'(sa.Step) > max_step) max_step = int'(sa.Step);
            if (sa.Wrapped === 1'b1) wr = 1;
        end
        n_tests++;
        if (wr !== 1'b1 || max_step !== 2) begin
            n_fail++;
            $display("FAIL drop_complete: wrapped=%0d max_step=%0d expected 1 2", wr, max_step);
        end
        n_tests++;
        if (sa.RoutineSel !== 3'd0 || sa.CycleCount !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_wrap_vals: sel=%0d cc=%0d expected 0 1", sa.RoutineSel, sa.CycleCount);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_tests++;
            if (pk_a() !== pack(0, 2, 0, 0, 0, 1, 0)) begin
                n_fail++;
                $display("FAIL drop_idle k=%0d: got %h expected %h", k, pk_a(), pack(0, 2, 0, 0, 0, 1, 0));
            end
        end
        sa.Tick = 0;
    endtask

    // Asynchronous reset mid-run clears every output without waiting for a clock.
    task automatic test_async_reset();
        do_reset();
        sa.Enable = 1;
        sb.Enable = 1;
        for (int k = 0; k < 6; k++) begin
            sa.Tick = 1;
            sb.Tick = 1;
            cyc();
        end
        sa.Tick = 0;
        sb.Tick = 0;
        n_tests++;
        if (sb.Active !== 1'b1 || sb.Step === 16'd0) begin
            n_fail++;
            $display("FAIL areset_pre: act=%0d step=%0d expected act=1 step>0", sb.Active, sb.Step);
        end
        @(posedge Clock);
        #2;
        ResetN = 0;
        sa.Enable = 0;
        sb.Enable = 0;
        #1;
        n_tests++;
        if (pk_b() !== 31'd0) begin n_fail++; $display("FAIL areset_big: got %h expected 0", pk_b()); end
        n_tests++;
        if (pk_a() !== 31'd0) begin n_fail++; $display("FAIL areset_small: got %h expected 0", pk_a()); end
        ResetN = 1;
        cyc();
        n_tests++;
        if (pk_b() !== 31'd0) begin n_fail++; $display("FAIL areset_after: got %h expected 0", pk_b()); end
    endtask

    // 256 full schedules: CycleCount reads 255 then rolls to 0.
    task automatic test_cycle_wrap();
        int wraps = 0;
        do_reset();
        sa.Enable = 1;
        sa.Tick = 1;
        for (int k = 0; k < 5000 && wraps < 256; k++) begin
            cyc();
            if (sa.Wrapped === 1'b1) begin
                wraps++;
                if (wraps == 255) begin
                    n_tests++;
                    if (sa.CycleCount !== 8'd255) begin
                        n_fail++;
                        $display("FAIL cc_255: got %0d expected 255", sa.CycleCount);
                    end
                end
                if (wraps == 256) begin
                    n_tests++;
                    if (sa.CycleCount !== 8'd0) begin
                        n_fail++;
                        $display("FAIL cc_rollover: got %0d expected 0", sa.CycleCount);
                    end
                end
            end
        end
        sa.Tick = 0;
        n_tests++;
        if (wraps !== 256) begin n_fail++; $display("FAIL cc_wrap_count: got %0d expected 256", wraps); end
    endtask

    // Timeline reference: walk routine by routine over the random input record.
    task automatic build_model();
        int t = 0;
        int sel = 0;
        int cc = 0;
        int step = 0;
        while (t < L) begin
            int d;
            bit wrap;
            d = dur_s[sel];
            step = 0;
            ex[t] = pack(sel, 0, d != 0, d != 0, 0, cc, 0);
            t++;
            if (d != 0) begin
                bit paused = 0;
                bit fin = 0;
                if (t < L) ex[t] = pack(sel, 0, 0, 1, d == 1, cc, 0);
                t++;
                while (!fin && t < L) begin
                    if (paused) paused = pz[t];
                    else if (sk[t] || dn[t]) fin = 1;
                    else if (pz[t]) paused = 1;
                    else if (tk[t]) begin
                        if (step == d - 1) fin = 1;
                        else step++;
                    end
                    if (!fin) begin
                        ex[t] = pack(sel, step, 0, 1, step == d - 1, cc, 0);
                        t++;
                    end
                end
            end
            wrap = (sel == 2);
            sel = wrap ? 0 : sel + 1;
            if (wrap) cc = (cc + 1) % 256;
            if (t < L) ex[t] = pack(sel, step, 0, 0, 0, cc, wrap);
            t++;
        end
    endtask

    task automatic test_random();
        bit p = 0;
        for (int k = 0; k < L; k++) begin
            tk[k] = ($urandom_range(0, 2) == 0);
            sk[k] = ($urandom_range(0, 59) == 0);
            dn[k] = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 11) == 0) p = ~p;
            pz[k] = p;
        end
        build_model();
        do_reset();
        for (int k = 0; k < L; k++) begin
            sa.Enable = 1;
            sa.Tick = tk[k];
            sa.Skip = sk[k];
            sa.RoutineDone = dn[k];
            sa.Pause = pz[k];
            cyc();
            n_tests++;
            if (pk_a() !== ex[k]) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got %h expected %h", k, pk_a(), ex[k]);
            end
        end
        zero_inputs();
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_latency();
        test_done_tick();
        test_pause();
        test_enable_drop();
        test_async_reset();
        test_cycle_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
